// File: rtl/output_unit_rr.sv
// Wormhole output unit: round-robin arbitration among NUM_PORTS inputs, packet-long lock,
// registered flit output stage and downstream credit counter.
module output_unit_rr #(
  parameter  int NUM_PORTS = 5,
  parameter  int FLIT_W    = 32,
  parameter  int CREDITS   = 4,
  localparam int CW        = $clog2(CREDITS + 1),
  localparam int PW        = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        i_req,
  input  logic [NUM_PORTS-1:0]        i_flit_valid,
  input  logic [NUM_PORTS-1:0]        i_flit_tail,
  input  logic [NUM_PORTS*FLIT_W-1:0] i_flit_data,
  output logic [NUM_PORTS-1:0]        o_grant,
  output logic [NUM_PORTS-1:0]        o_flit_ready,
  output logic                        o_flit_valid,
  output logic                        o_flit_tail,
  output logic [FLIT_W-1:0]           o_flit_data,
  input  logic                        i_credit_ret,
  output logic [CW-1:0]               o_credits,
  output logic                        o_busy,
  output logic                        o_credit_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         owner;
  logic [PW-1:0]         winner;
  logic [NUM_PORTS-1:0]  winner_oh;
  logic                  found;
  logic [CW-1:0]         credits;
  logic                  xfer;
  logic                  owner_tail;
  logic [FLIT_W-1:0]     owner_data;

  // First requester at or above rr_ptr, wrapping modulo NUM_PORTS.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    winner    = rr_ptr;
    winner_oh = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && i_req[idx]) begin
        found          = 1'b1;
        winner         = PW'(idx);
        winner_oh[idx] = 1'b1;
      end
    end
  end

  // o_grant is one-hot on the owner while locked, so masking valid with it selects the owner.
  assign o_flit_ready = (credits != '0) ? (o_grant & i_flit_valid) : '0;
  assign xfer         = |o_flit_ready;
  assign owner_tail   = i_flit_tail[owner];
  assign owner_data   = i_flit_data[int'(owner)*FLIT_W +: FLIT_W];
  assign o_credits    = credits;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      o_grant <= '0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner   <= winner;
            o_grant <= winner_oh;
            o_busy  <= 1'b1;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && owner_tail) begin
            o_grant <= '0;
            o_busy  <= 1'b0;
            rr_ptr  <= (owner == PW'(NUM_PORTS - 1)) ? '0 : owner + PW'(1);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage pulses valid once per accepted flit; tail is qualified the same way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_flit_valid <= 1'b0;
      o_flit_tail  <= 1'b0;
      o_flit_data  <= '0;
    end else begin
      o_flit_valid <= xfer;
      o_flit_tail  <= xfer & owner_tail;
      if (xfer) o_flit_data <= owner_data;
    end
  end

  // A return into a full counter is dropped and flagged; send+return cancels out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits      <= CW'(CREDITS);
      o_credit_err <= 1'b0;
    end else begin
      case ({xfer, i_credit_ret})
        2'b10: credits <= credits - CW'(1);
        2'b01: begin
          if (credits == CW'(CREDITS)) o_credit_err <= 1'b1;
          else                         credits      <= credits + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
